sr_latch_sched: RTL and testbench

SR_LATCH_SCHED -- requirements
Module: sr_latch_sched

---
 rtl/sr_latch_pkg.sv | 19 +
 rtl/sr_latch.sv | 15 +
 rtl/sr_latch_sched_rr_arb2.sv | 45 ++++
 rtl/sr_latch_sched.sv | 128 ++++++++++++
 tb/tb_sr_latch_sched.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sr_latch_pkg.sv
// Shared types and constants for the SR-latch pulse scheduler.
package sr_latch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    localparam int DEF_N        = 8;
    localparam int DEF_PULSE_W  = 2;
    localparam int DEF_SETTLE_W = 3;

endpackage

// File: rtl/sr_latch.sv
// Behavioural set/reset latch used as a bank element around the scheduler.
module sr_latch (
    input  logic s_i,
    input  logic r_i,
    output logic q_o
);

    // Transparent while either drive is active; set wins only by never overlapping
    always_latch begin
        if (s_i || r_i) begin
            q_o <= s_i;
        end
    end

endmodule

// File: rtl/sr_latch_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the favoured requester
// and moves to the other one only when a grant is actually issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and next pointer
    always_comb begin
        grant_o = 2'b00;
        ptr_d   = ptr_q;
        if (grant_en_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
            if (grant_o != 2'b00) begin
                ptr_d = grant_o[0];
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            grant_o = 2'b00;
            ptr_d   = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sr_latch_sched.sv
// Serialises set/clear requests from two masters onto an SR latch bank:
// pulse, settle, read back and report mismatch with a one-cycle ack.
module sr_latch_sched
    import sr_latch_pkg::*;
#(
    parameter int  N        = DEF_N,
    parameter int  PULSE_W  = DEF_PULSE_W,
    parameter int  SETTLE_W = DEF_SETTLE_W,
    localparam int IDX_W    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       op,
    input  logic [IDX_W-1:0] idx0,
    input  logic [IDX_W-1:0] idx1,
    output logic [1:0]       ack,
    output logic             err,
    output logic [N-1:0]     S_vec,
    output logic [N-1:0]     R_vec,
    input  logic [N-1:0]     Q_vec,
    output logic             busy
);

    localparam logic [N-1:0] ONE_N = N'(1);

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic [1:0]       gnt_q;
    logic             op_q;
    logic [IDX_W-1:0] idx_q;

    logic [1:0]       grant_s;
    logic             sel_op_d;
    logic [IDX_W-1:0] sel_idx_d;
    logic [N-1:0]     sel_hit_s;
    logic [N-1:0]     hit_vec_s;
    logic             mismatch_s;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .grant_en_i (state_q == ST_IDLE),
        .grant_o    (grant_s)
    );

    // Operand mux for the granted requester; an index >= N shifts out to an empty mask
    always_comb begin
        sel_op_d   = grant_s[1] ? op[1] : op[0];
        sel_idx_d  = grant_s[1] ? idx1 : idx0;
        sel_hit_s  = ONE_N << sel_idx_d;
        hit_vec_s  = ONE_N << idx_q;
        mismatch_s = (hit_vec_s == '0) || ((|(Q_vec & hit_vec_s)) != op_q);
    end

    // Sequencer with registered latch drives, ack, err and busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            gnt_q   <= 2'b00;
            op_q    <= 1'b0;
            idx_q   <= '0;
            S_vec   <= '0;
            R_vec   <= '0;
            ack     <= 2'b00;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_s != 2'b00) begin
                        gnt_q   <= grant_s;
                        op_q    <= sel_op_d;
                        idx_q   <= sel_idx_d;
                        cnt_q   <= 4'(PULSE_W - 1);
                        S_vec   <= (sel_op_d == OP_SET) ? sel_hit_s : '0;
                        R_vec   <= (sel_op_d == OP_SET) ? '0 : sel_hit_s;
                        busy    <= 1'b1;
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == 4'd0) begin
                        S_vec   <= '0;
                        R_vec   <= '0;
                        cnt_q   <= 4'(SETTLE_W - 1);
                        state_q <= ST_SETTLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_CHECK: begin
                    err     <= mismatch_s;
                    ack     <= gnt_q;
                    cnt_q   <= 4'd0;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    ack     <= 2'b00;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    cnt_q   <= 4'd0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    S_vec   <= '0;
                    R_vec   <= '0;
                    ack     <= 2'b00;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    cnt_q   <= 4'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_sched.sv
// Scoreboard bench for sr_latch_sched driving a real bank of sr_latch models.
module tb_sr_latch_sched;

    localparam int N        = 8;
    localparam int PULSE_W  = 2;
    localparam int SETTLE_W = 3;
    localparam int IDX_W    = $clog2(N + 1);
    localparam int LAT      = PULSE_W + SETTLE_W + 2;

    typedef struct {
        logic [1:0]   ack;
        logic         err;
        int           grant_cyc;
        int           ack_cyc;
        logic [N-1:0] s;
        logic [N-1:0] r;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req = 2'b00;
    logic [1:0]       op  = 2'b00;
    logic [IDX_W-1:0] idx0 = '0;
    logic [IDX_W-1:0] idx1 = '0;
    logic [1:0]       ack;
    logic             err;
    logic             busy;
    logic [N-1:0]     S_vec;
    logic [N-1:0]     R_vec;
    logic [N-1:0]     Q_vec;
    logic [N-1:0]     lq;
    logic [N-1:0]     stuck_mask = '0;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ptr_m    = 0;
    exp_t sb[$];
    exp_t m_e;
    logic [N-1:0] m_es;
    logic [N-1:0] m_er;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign Q_vec = lq & ~stuck_mask;

    for (genvar g = 0; g < N; g++) begin : g_bank
        sr_latch u_latch (.s_i(S_vec[g]), .r_i(R_vec[g]), .q_o(lq[g]));
    end

    sr_latch_sched #(.N(N), .PULSE_W(PULSE_W), .SETTLE_W(SETTLE_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .op    (op),
        .idx0  (idx0),
        .idx1  (idx1),
        .ack   (ack),
        .err   (err),
        .S_vec (S_vec),
        .R_vec (R_vec),
        .Q_vec (Q_vec),
        .busy  (busy)
    );

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference model: who wins, what the bank should see, and what err must be
    task automatic predict(input logic [1:0] rq, output exp_t e, output int who);
        logic o;
        int   ix;
        if (rq == 2'b11) who = ptr_m;
        else             who = rq[1] ? 1 : 0;
        ptr_m = 1 - who;
        o  = (who == 1) ? op[1] : op[0];
        ix = (who == 1) ? int'(idx1) : int'(idx0);
        e.ack = (who == 1) ? 2'b10 : 2'b01;
        e.s = '0;
        e.r = '0;
        for (int b = 0; b < N; b++) begin
            if (b == ix) begin
                if (o) e.s[b] = 1'b1;
                else   e.r[b] = 1'b1;
            end
        end
        if (ix >= N) e.err = 1'b1;
        else         e.err = o && stuck_mask[ix];
        e.grant_cyc = cyc;
        e.ack_cyc   = cyc + LAT;
    endtask

    task automatic do_txn(input logic [1:0] rq, input logic o0, input logic [IDX_W-1:0] i0,
                          input logic o1, input logic [IDX_W-1:0] i1, input bit hold);
        exp_t e;
        int   who;
        bit   got;
        op   = {o1, o0};
        idx0 = i0;
        idx1 = i1;
        req  = rq;
        predict(rq, e, who);
        sb.push_back(e);
        got = 1'b0;
        for (int k = 0; k < LAT + 10; k++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack_timeout", 1'b0, 64'(ack), 64'(e.ack));
        if (!hold) req = req & ~e.ack;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        sb.delete();
        repeat (2) @(negedge clk);
        check("rst_S",    S_vec == '0, 64'(S_vec), 64'd0);
        check("rst_R",    R_vec == '0, 64'(R_vec), 64'd0);
        check("rst_ack",  ack == 2'b00, 64'(ack), 64'd0);
        check("rst_err",  err == 1'b0, 64'(err), 64'd0);
        check("rst_busy", busy == 1'b0, 64'(busy), 64'd0);
        rst   = 1'b0;
        ptr_m = 0;
    endtask

    // Monitor: per-cycle drive legality and ack/err/latency against the queue
    always @(negedge clk) begin
        if (!rst) begin
            m_es = '0;
            m_er = '0;
            if (sb.size() > 0 && cyc > sb[0].grant_cyc && cyc <= sb[0].grant_cyc + PULSE_W) begin
                m_es = sb[0].s;
                m_er = sb[0].r;
            end
            check("sr_drive", {S_vec, R_vec} == {m_es, m_er}, 64'({S_vec, R_vec}), 64'({m_es, m_er}));
            check("sr_exclusive", ((S_vec & R_vec) == '0) && ($countones(S_vec | R_vec) <= 1),
                  64'({S_vec, R_vec}), 64'd0);
            if (ack != 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 1'b0, 64'(ack), 64'd0);
                end else begin
                    m_e = sb.pop_front();
                    check("ack_who",   ack == m_e.ack, 64'(ack), 64'(m_e.ack));
                    check("ack_err",   err == m_e.err, 64'(err), 64'(m_e.err));
                    check("ack_cycle", cyc == m_e.ack_cyc, 64'(cyc), 64'(m_e.ack_cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   who;

        do_reset();

        // single set of latch 3
        do_txn(2'b01, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        check("q3_set", lq[3] == 1'b1, 64'(lq[3]), 64'd1);

        // both request from reset: 0 first, then 1 clears the same latch
        do_reset();
        do_txn(2'b11, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        check("q0_after_set", lq[0] == 1'b1, 64'(lq[0]), 64'd1);
        do_txn(2'b10, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        check("q0_final", lq[0] == 1'b0, 64'(lq[0]), 64'd0);

        // continuous dual request: grants must alternate
        for (int t = 0; t < 8; t++) begin
            do_txn(2'b11, 1'($urandom_range(0, 1)), 4'($urandom_range(0, N - 1)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, N - 1)), 1'b1);
        end
        req = 2'b00;
        @(negedge clk);

        // stuck-at-0 readback on bit 5
        stuck_mask = 8'h20;
        do_txn(2'b01, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        do_txn(2'b01, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0);
        stuck_mask = 8'h00;

        // reset during the second drive cycle
        op   = 2'b01;
        idx0 = 4'd6;
        req  = 2'b01;
        predict(2'b01, e, who);
        sb.push_back(e);
        repeat (2) @(negedge clk);
        check("busy_in_drive", busy == 1'b1, 64'(busy), 64'd1);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        check("middrive_S",    S_vec == '0, 64'(S_vec), 64'd0);
        check("middrive_R",    R_vec == '0, 64'(R_vec), 64'd0);
        check("middrive_busy", busy == 1'b0, 64'(busy), 64'd0);
        check("middrive_ack",  ack == 2'b00, 64'(ack), 64'd0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        ptr_m = 0;
        repeat (10) @(negedge clk);
        do_txn(2'b01, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0);

        // out-of-range index: no drive, err at ack
        do_txn(2'b01, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0);

        // randomized traffic including out-of-range indices
        for (int t = 0; t < 30; t++) begin
            do_txn(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)), 1'b0);
        end
        req = 2'b00;

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size() == 0, 64'(sb.size()), 64'd0);
        check("idle_busy", busy == 1'b0, 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
